// File: rtl/pl_pkg.sv
// rtl/pl_pkg.sv - shared opcodes, fetch state encoding and defaults for the RISC-RNS pipeline
package pl_pkg;

  localparam int DEFAULT_PROG_CTR_WID = 10;

  typedef enum logic [4:0] {
    OP_NOP = 5'b00000,
    OP_ADD = 5'b00001,
    OP_SUB = 5'b00010,
    OP_LD  = 5'b00011,
    OP_ST  = 5'b00100,
    OP_BEQ = 5'b00101,
    OP_BNE = 5'b00110,
    OP_JMP = 5'b00111
  } opcode_e;

  typedef enum logic [1:0] {
    FS_WAIT  = 2'd0,
    FS_RUN   = 2'd1,
    FS_STALL = 2'd2,
    FS_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pl_sat_counter.sv
// rtl/pl_sat_counter.sv - saturating up-counter with increment enable and synchronous clear
module pl_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pl_fetch_ctrl.sv
// rtl/pl_fetch_ctrl.sv - PC and instruction-fetch controller; FETCH_HALT_DETECT_EN adds self-jump halt
module pl_fetch_ctrl
  import pl_pkg::*;
#(
  parameter int                      PROG_CTR_WID = DEFAULT_PROG_CTR_WID,
  parameter logic [PROG_CTR_WID-1:0] RESET_VECTOR = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_in,
  input  logic                    branch_taken_EX,
  input  logic [PROG_CTR_WID-1:0] branch_target_EX,
  input  logic [15:0]             instr_mem_out,
  output logic [PROG_CTR_WID-1:0] instr_mem_addr,
  output logic                    instr_mem_en,
  output logic                    instr_valid,
  output logic [PROG_CTR_WID-1:0] fetch_pc,
  output logic                    halted,
  output logic [15:0]             fetch_count
);

  localparam logic [PROG_CTR_WID-1:0] PC_ONE = {{(PROG_CTR_WID-1){1'b0}}, 1'b1};

  fetch_state_e            state_q, state_d;
  logic [PROG_CTR_WID-1:0] pc_q, pc_d;
  logic [PROG_CTR_WID-1:0] addr_q, addr_d;
  logic [PROG_CTR_WID-1:0] fpc_q, fpc_d;
  logic                    en_q, en_d;
  logic                    valid_q, valid_d;
  logic                    halted_q, halted_d;
  logic                    cnt_inc;
  logic                    halt_trig;

`ifdef FETCH_HALT_DETECT_EN
  logic [PROG_CTR_WID-1:0] jmp_tgt;
  logic                    unused_mem_bit;

  // Jump field is 10 bits; zero-extend or truncate to the PC width.
  always_comb begin
    jmp_tgt = '0;
    for (int i = 0; (i < PROG_CTR_WID) && (i < 10); i++) begin
      jmp_tgt[i] = instr_mem_out[i];
    end
  end

  assign halt_trig      = (state_q == FS_RUN) && valid_q &&
                          (instr_mem_out[15:11] == OP_JMP) && (jmp_tgt == fpc_q);
  assign unused_mem_bit = instr_mem_out[10];
`else
  logic unused_mem_word;

  assign halt_trig       = 1'b0;
  assign unused_mem_word = ^instr_mem_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_WAIT: state_d = FS_RUN;
      FS_RUN: begin
        if (branch_taken_EX)  state_d = FS_RUN;
        else if (halt_trig)   state_d = FS_HALT;
        else if (stall_in)    state_d = FS_STALL;
        else                  state_d = FS_RUN;
      end
      FS_STALL: begin
        if (branch_taken_EX)  state_d = FS_RUN;
        else if (stall_in)    state_d = FS_STALL;
        else                  state_d = FS_RUN;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    addr_d   = addr_q;
    fpc_d    = fpc_q;
    en_d     = en_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    cnt_inc  = 1'b0;
    case (state_q)
      FS_WAIT: begin
        addr_d = pc_q;
        pc_d   = pc_q + PC_ONE;
        en_d   = 1'b1;
      end
      FS_RUN, FS_STALL: begin
        if (branch_taken_EX) begin
          // The word arriving next cycle was fetched down the wrong path.
          addr_d  = branch_target_EX;
          pc_d    = branch_target_EX + PC_ONE;
          valid_d = 1'b0;
        end else if (halt_trig) begin
          en_d     = 1'b0;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else if (!stall_in) begin
          addr_d  = pc_q;
          pc_d    = pc_q + PC_ONE;
          fpc_d   = addr_q;
          valid_d = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_VECTOR;
      addr_q   <= RESET_VECTOR;
      fpc_q    <= RESET_VECTOR;
      en_q     <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      fpc_q    <= fpc_d;
      en_q     <= en_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  pl_sat_counter #(
    .WIDTH(16)
  ) u_fetch_cnt (
    .clk    (clk),
    .clr_i  (rst),
    .inc_i  (cnt_inc),
    .count_o(fetch_count)
  );

  assign instr_mem_addr = addr_q;
  assign instr_mem_en   = en_q;
  assign instr_valid    = valid_q;
  assign fetch_pc       = fpc_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_pl_fetch_ctrl.sv
// tb/tb_pl_fetch_ctrl.sv - self-checking bench for pl_fetch_ctrl against a transaction-level fetch model
module tb_pl_fetch_ctrl;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stall_in = 1'b0;
  logic         branch_taken_EX = 1'b0;
  logic [W-1:0] branch_target_EX = '0;
  logic [15:0]  instr_mem_out = '0;
  logic [W-1:0] instr_mem_addr;
  logic         instr_mem_en;
  logic         instr_valid;
  logic [W-1:0] fetch_pc;
  logic         halted;
  logic [15:0]  fetch_count;

  logic [15:0]  mem [0:1023];

  int checks = 0;
  int errors = 0;

  bit           m_started, m_held, m_halted, m_valid, m_en;
  logic [W-1:0] m_addr, m_fpc;
  int           m_count;

  pl_fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stall_in        (stall_in),
    .branch_taken_EX (branch_taken_EX),
    .branch_target_EX(branch_target_EX),
    .instr_mem_out   (instr_mem_out),
    .instr_mem_addr  (instr_mem_addr),
    .instr_mem_en    (instr_mem_en),
    .instr_valid     (instr_valid),
    .fetch_pc        (fetch_pc),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (instr_mem_en) instr_mem_out <= mem[instr_mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_held = 0; m_halted = 0; m_valid = 0; m_en = 0;
    m_addr = '0; m_fpc = '0; m_count = 0;
  endtask

  // Fetch as seen from outside: one address on the bus, one word presented, count of words presented.
  task automatic model_edge(input logic [15:0] word);
    if (rst) begin
      model_reset();
    end else if (m_halted) begin
    end else if (!m_started) begin
      m_started = 1; m_addr = '0; m_en = 1;
    end else if (branch_taken_EX) begin
      m_addr = branch_target_EX; m_valid = 0; m_held = 0;
`ifdef FETCH_HALT_DETECT_EN
    end else if (m_valid && !m_held && word[15:11] == 5'b00111 && word[9:0] == m_fpc) begin
      m_halted = 1; m_en = 0; m_valid = 0;
`endif
    end else if (stall_in) begin
      m_held = 1;
    end else begin
      m_fpc = m_addr; m_addr = m_addr + 1'b1; m_valid = 1; m_held = 0;
      if (m_count < 65535) m_count++;
    end
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".addr"},   32'(instr_mem_addr), 32'(m_addr));
    check({ph, ".en"},     32'(instr_mem_en),   32'(m_en));
    check({ph, ".valid"},  32'(instr_valid),    32'(m_valid));
    check({ph, ".pc"},     32'(fetch_pc),       32'(m_fpc));
    check({ph, ".halted"}, 32'(halted),         32'(m_halted));
    check({ph, ".count"},  32'(fetch_count),    32'(m_count));
  endtask

  task automatic drive(input bit st, input bit br, input logic [W-1:0] tgt);
    stall_in = st; branch_taken_EX = br; branch_target_EX = tgt;
  endtask

  task automatic step(input string ph, input bit chk);
    logic [15:0] word;
    word = instr_mem_out;
    @(posedge clk);
    model_edge(word);
    #1;
    if (chk) compare_all(ph);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          frozen;
    int          guard;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      if (w[15:11] == 5'b00111) w[15:11] = 5'b01000;
      mem[i] = w[15:0];
    end
    model_reset();

    rst = 1'b1; drive(0, 0, '0);
    step("reset", 1); step("reset", 1);
    check("reset.addr0", 32'(instr_mem_addr), 32'h0);
    check("reset.count0", 32'(fetch_count), 32'h0);

    rst = 1'b0;
    for (int i = 0; i < 4; i++) step("startup", 1);
    check("startup.pc_e3", 32'(fetch_pc), 32'h2);
    check("startup.count_e3", 32'(fetch_count), 32'h3);

    step("seq", 1);
    drive(0, 1, 10'h3F0); step("br3f0.bubble", 1);
    check("br3f0.bubble_valid", 32'(instr_valid), 32'h0);
    drive(0, 0, '0);
    step("br3f0", 1); check("br3f0.first", 32'(fetch_pc), 32'h3F0);
    step("br3f0", 1); check("br3f0.second", 32'(fetch_pc), 32'h3F1);
    step("br3f0", 1); check("br3f0.third", 32'(fetch_pc), 32'h3F2);

    drive(0, 1, 10'd6); step("br6", 1);
    drive(0, 0, '0); step("br6", 1); step("br6", 1);
    check("stall.pre_pc", 32'(fetch_pc), 32'h7);
    frozen = m_count;
    drive(1, 0, '0);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1);
      check("stall.pc_hold", 32'(fetch_pc), 32'h7);
      check("stall.addr_hold", 32'(instr_mem_addr), 32'h8);
      check("stall.count_hold", 32'(fetch_count), 32'(frozen));
    end
    drive(0, 0, '0);
    step("unstall", 1); check("unstall.pc8", 32'(fetch_pc), 32'h8);
    step("unstall", 1); check("unstall.pc9", 32'(fetch_pc), 32'h9);

    drive(1, 1, 10'h100); step("stallbr", 1);
    check("stallbr.addr", 32'(instr_mem_addr), 32'h100);
    drive(0, 0, '0); step("stallbr", 1);
    check("stallbr.pc", 32'(fetch_pc), 32'h100);

    drive(0, 1, 10'h3FF); step("wrap", 1);
    drive(0, 0, '0);
    step("wrap", 1); check("wrap.pc3ff", 32'(fetch_pc), 32'h3FF);
    step("wrap", 1); check("wrap.pc000", 32'(fetch_pc), 32'h0);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), W'($urandom_range(0, 1023)));
      step("rand", 1);
    end

    drive(0, 0, '0); rst = 1'b1; step("midrst", 1);
    check("midrst.valid", 32'(instr_valid), 32'h0);
    check("midrst.count", 32'(fetch_count), 32'h0);
    rst = 1'b0; drive(1, 0, '0);
    step("wait_ignores_stall", 1);
    check("wait.en", 32'(instr_mem_en), 32'h1);
    drive(0, 0, '0);

    guard = 0;
    while (m_count < 16'hFFFE && guard < 70000) begin
      step("long", 0);
      guard++;
    end
    compare_all("sat.pre");
    check("sat.fffe", 32'(fetch_count), 32'hFFFE);
    step("sat", 1); check("sat.ffff", 32'(fetch_count), 32'hFFFF);
    step("sat", 1); check("sat.hold", 32'(fetch_count), 32'hFFFF);

    mem[5] = 16'h3805;
    rst = 1'b1; step("halt.rst", 1);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) step("halt.run", 1);
`ifdef FETCH_HALT_DETECT_EN
    check("halt.halted", 32'(halted), 32'h1);
    check("halt.en", 32'(instr_mem_en), 32'h0);
    check("halt.valid", 32'(instr_valid), 32'h0);
    check("halt.pc", 32'(fetch_pc), 32'h5);
`else
    check("nohalt.halted", 32'(halted), 32'h0);
`endif
    drive(0, 1, 10'h200); step("halt.br", 1);
    drive(1, 0, '0); step("halt.stall", 1);
    drive(0, 0, '0);
    rst = 1'b1; step("halt.clear", 1);
    check("halt.cleared", 32'(halted), 32'h0);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
